// File: rtl/sfifo_axis_reader.sv
// Drains a synchronous FIFO read port into an AXI-stream master through a
// 2-entry buffer, framing the stream into packets of programmable length.
module sfifo_axis_reader #(
  parameter int BW       = 8,
  parameter int LGPKT    = 8,
  parameter bit OPT_FWFT = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  output logic             o_rd,
  input  logic [BW-1:0]    i_data,
  input  logic             i_empty,
  input  logic [LGPKT-1:0] i_pkt_last,
  output logic             M_AXIS_TVALID,
  input  logic             M_AXIS_TREADY,
  output logic [BW-1:0]    M_AXIS_TDATA,
  output logic             M_AXIS_TLAST,
  output logic [15:0]      o_pkt_count,
  output logic             o_busy
);

  logic [1:0]       entries;
  logic             inflight;
  logic [BW-1:0]    head_p1;
  logic [BW-1:0]    skid_p1;
  logic [LGPKT-1:0] beat_cnt;
  logic [LGPKT-1:0] len_q;
  logic             pop;
  logic             cap;
  logic             last_beat;
  logic [2:0]       occ;

  assign pop = M_AXIS_TVALID && M_AXIS_TREADY;

  // Slots still committed after this cycle's pop; an in-flight read already owns one.
  assign occ  = {1'b0, entries} + {2'b00, inflight} - {2'b00, pop};
  assign o_rd = !i_reset && !i_empty && (occ < 3'd2);

  // ---- p0: FIFO read issue / data return ----
  generate
    if (OPT_FWFT) begin : g_fwft
      assign inflight = 1'b0;
      assign cap      = o_rd;
    end else begin : g_reg
      always_ff @(posedge i_clk) begin
        if (i_reset)
          inflight <= 1'b0;
        else
          inflight <= o_rd;
      end
      assign cap = inflight;
    end
  endgenerate

  // ---- p1: 2-entry output buffer (head drives TDATA, skid behind it) ----
  always_ff @(posedge i_clk) begin
    if (pop && (entries == 2'd2))
      head_p1 <= skid_p1;
    else if (cap && ((entries == 2'd0) || pop))
      head_p1 <= i_data;

    if (cap && (((entries == 2'd1) && !pop) || ((entries == 2'd2) && pop)))
      skid_p1 <= i_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      entries <= 2'd0;
    end else begin
      case ({cap, pop})
        2'b10:   entries <= entries + 2'd1;
        2'b01:   entries <= entries - 2'd1;
        default: entries <= entries;
      endcase
    end
  end

  // Packet length is latched only at packet boundaries so mid-packet edits are deferred.
  assign last_beat = (beat_cnt == len_q);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      beat_cnt    <= '0;
      len_q       <= i_pkt_last;
      o_pkt_count <= 16'd0;
    end else if (pop) begin
      if (last_beat) begin
        beat_cnt    <= '0;
        len_q       <= i_pkt_last;
        o_pkt_count <= o_pkt_count + 16'd1;
      end else begin
        beat_cnt <= beat_cnt + 1'b1;
      end
    end
  end

  assign M_AXIS_TVALID = (entries != 2'd0);
  assign M_AXIS_TDATA  = head_p1;
  assign M_AXIS_TLAST  = M_AXIS_TVALID && last_beat;
  assign o_busy        = (entries != 2'd0) || inflight;

endmodule

// File: tb/tb_sfifo_axis_reader.sv
// Bench for sfifo_axis_reader: dut0 uses a registered-read FIFO model,
// dut1 a first-word-fall-through FIFO model.
module tb_sfifo_axis_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]      rst;
  logic [1:0]      tready;
  logic [1:0]      empty;
  logic [1:0][7:0] din;
  logic [1:0][7:0] pkt_last;
  wire  [1:0]      rd;
  wire  [1:0]      tvalid;
  wire  [1:0]      tlast;
  wire  [1:0]      busy;
  wire  [1:0][7:0] tdata;
  wire  [1:0][15:0] pcnt;

  sfifo_axis_reader #(.BW(8), .LGPKT(8), .OPT_FWFT(1'b0)) dut0 (
    .i_clk(clk), .i_reset(rst[0]), .o_rd(rd[0]), .i_data(din[0]), .i_empty(empty[0]),
    .i_pkt_last(pkt_last[0]), .M_AXIS_TVALID(tvalid[0]), .M_AXIS_TREADY(tready[0]),
    .M_AXIS_TDATA(tdata[0]), .M_AXIS_TLAST(tlast[0]), .o_pkt_count(pcnt[0]), .o_busy(busy[0])
  );

  sfifo_axis_reader #(.BW(8), .LGPKT(8), .OPT_FWFT(1'b1)) dut1 (
    .i_clk(clk), .i_reset(rst[1]), .o_rd(rd[1]), .i_data(din[1]), .i_empty(empty[1]),
    .i_pkt_last(pkt_last[1]), .M_AXIS_TVALID(tvalid[1]), .M_AXIS_TREADY(tready[1]),
    .M_AXIS_TDATA(tdata[1]), .M_AXIS_TLAST(tlast[1]), .o_pkt_count(pcnt[1]), .o_busy(busy[1])
  );

  int compared = 0;
  int failed   = 0;

  logic [7:0] mem [2][64];
  int         wcnt [2];
  int         rp [2];
  logic       rdq [2];
  logic [7:0] lastword [2];
  logic       rd_s [2];
  logic       prev_stall [2];
  logic [7:0] prev_d [2];
  logic       prev_l [2];
  logic [7:0] gd [2][64];
  logic       gl [2][64];
  int         gn [2];

  typedef struct {
    int         push_n;
    logic [7:0] push_base;
    logic       tready;
    logic [7:0] pkt_last;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic       exp_last;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t tbl [20];

  function automatic vec_t mk(int pn, int pb, int tr, int pl, int ev, int ed, int el, int ec);
    vec_t v;
    v.push_n    = pn;
    v.push_base = pb[7:0];
    v.tready    = tr[0];
    v.pkt_last  = pl[7:0];
    v.exp_valid = ev[0];
    v.exp_data  = ed[7:0];
    v.exp_last  = el[0];
    v.exp_cnt   = ec[15:0];
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Present FIFO outputs from the model: FWFT shows the head word, registered
  // mode returns the word popped on the previous cycle.
  task automatic drive();
    for (int i = 0; i < 2; i++) begin
      empty[i] = (rp[i] == wcnt[i]);
      if (i == 1)
        din[i] = empty[i] ? 8'hEE : mem[i][rp[i]];
      else
        din[i] = rdq[i] ? lastword[i] : 8'hEE;
    end
  endtask

  task automatic push(input int i, input int n, input logic [7:0] base);
    for (int k = 0; k < n; k++) begin
      mem[i][wcnt[i]] = base + 8'(k);
      wcnt[i]++;
    end
    drive();
  endtask

  task automatic half();
    @(negedge clk);
    chk("occupancy0", 32'(({1'b0, dut0.entries} + {2'b00, dut0.inflight}) <= 3'd2), 32'd1);
    chk("occupancy1", 32'(({1'b0, dut1.entries} + {2'b00, dut1.inflight}) <= 3'd2), 32'd1);
    for (int i = 0; i < 2; i++) begin
      rd_s[i] = rd[i];
      chk($sformatf("rd_while_empty%0d", i), 32'(rd[i] & empty[i]), 32'd0);
      if (prev_stall[i]) begin
        chk($sformatf("stall_valid%0d", i), 32'(tvalid[i]), 32'd1);
        chk($sformatf("stall_data%0d", i), 32'(tdata[i]), 32'(prev_d[i]));
        chk($sformatf("stall_last%0d", i), 32'(tlast[i]), 32'(prev_l[i]));
      end
      if (!rst[i] && tvalid[i] && tready[i]) begin
        gd[i][gn[i]] = tdata[i];
        gl[i][gn[i]] = tlast[i];
        if (gn[i] < 63) gn[i]++;
      end
      prev_stall[i] = !rst[i] && tvalid[i] && !tready[i];
      prev_d[i]     = tdata[i];
      prev_l[i]     = tlast[i];
    end
  endtask

  task automatic fin();
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (rd_s[i]) begin
        lastword[i] = mem[i][rp[i]];
        rp[i]++;
      end
      rdq[i] = rd_s[i];
    end
    drive();
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      half();
      fin();
    end
  endtask

  initial begin
    int first;
    int lp;
    logic pat [7];

    for (int i = 0; i < 2; i++) begin
      wcnt[i] = 0; rp[i] = 0; rdq[i] = 1'b0; lastword[i] = 8'h00; rd_s[i] = 1'b0;
      prev_stall[i] = 1'b0; prev_d[i] = 8'h00; prev_l[i] = 1'b0; gn[i] = 0;
    end
    rst         = 2'b11;
    tready      = 2'b11;
    pkt_last[0] = 8'd0;
    pkt_last[1] = 8'd3;
    drive();

    tbl[0]  = mk(8, 'h11, 1, 3, 0, 0,    0, 0);
    tbl[1]  = mk(0, 0,    1, 3, 1, 'h11, 0, 0);
    tbl[2]  = mk(0, 0,    1, 3, 1, 'h12, 0, 0);
    tbl[3]  = mk(0, 0,    1, 3, 1, 'h13, 0, 0);
    tbl[4]  = mk(0, 0,    1, 3, 1, 'h14, 1, 0);
    tbl[5]  = mk(0, 0,    1, 3, 1, 'h15, 0, 1);
    tbl[6]  = mk(0, 0,    1, 3, 1, 'h16, 0, 1);
    tbl[7]  = mk(0, 0,    1, 3, 1, 'h17, 0, 1);
    tbl[8]  = mk(0, 0,    1, 3, 1, 'h18, 1, 1);
    tbl[9]  = mk(0, 0,    1, 3, 0, 0,    0, 2);
    tbl[10] = mk(8, 'h21, 1, 3, 0, 0,    0, 2);
    tbl[11] = mk(0, 0,    1, 3, 1, 'h21, 0, 2);
    tbl[12] = mk(0, 0,    1, 3, 1, 'h22, 0, 2);
    tbl[13] = mk(0, 0,    1, 1, 1, 'h23, 0, 2);
    tbl[14] = mk(0, 0,    1, 1, 1, 'h24, 1, 2);
    tbl[15] = mk(0, 0,    1, 1, 1, 'h25, 0, 3);
    tbl[16] = mk(0, 0,    1, 1, 1, 'h26, 1, 3);
    tbl[17] = mk(0, 0,    1, 1, 1, 'h27, 0, 4);
    tbl[18] = mk(0, 0,    1, 1, 1, 'h28, 1, 4);
    tbl[19] = mk(0, 0,    1, 1, 0, 0,    0, 5);

    // Reset state
    cyc(2);
    half();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_valid%0d", i), 32'(tvalid[i]), 32'd0);
      chk($sformatf("rst_last%0d", i), 32'(tlast[i]), 32'd0);
      chk($sformatf("rst_busy%0d", i), 32'(busy[i]), 32'd0);
      chk($sformatf("rst_cnt%0d", i), 32'(pcnt[i]), 32'd0);
      chk($sformatf("rst_rd%0d", i), 32'(rd[i]), 32'd0);
    end
    fin();
    rst = 2'b00;

    // FWFT streaming and mid-packet length change, cycle by cycle
    for (int v = 0; v < 20; v++) begin
      if (tbl[v].push_n > 0) push(1, tbl[v].push_n, tbl[v].push_base);
      tready[1]   = tbl[v].tready;
      pkt_last[1] = tbl[v].pkt_last;
      half();
      chk($sformatf("tbl%0d_valid", v), 32'(tvalid[1]), 32'(tbl[v].exp_valid));
      if (tbl[v].exp_valid) begin
        chk($sformatf("tbl%0d_data", v), 32'(tdata[1]), 32'(tbl[v].exp_data));
        chk($sformatf("tbl%0d_last", v), 32'(tlast[1]), 32'(tbl[v].exp_last));
      end
      chk($sformatf("tbl%0d_cnt", v), 32'(pcnt[1]), 32'(tbl[v].exp_cnt));
      fin();
    end

    // Registered-read FIFO: 2-cycle latency, then one beat per cycle
    gn[0] = 0;
    first = -1;
    lp    = -1;
    push(0, 6, 8'hA0);
    for (int c = 0; c < 20; c++) begin
      half();
      if (tvalid[0] && first < 0) first = c;
      if (tvalid[0] && tready[0]) lp = c;
      fin();
    end
    chk("reg_first_valid", 32'(first), 32'd2);
    chk("reg_beats", 32'(gn[0]), 32'd6);
    chk("reg_span", 32'(lp - first), 32'd5);
    for (int k = 0; k < 6; k++)
      chk($sformatf("reg_data%0d", k), 32'(gd[0][k]), 32'(8'hA0 + 8'(k)));

    // Backpressure on both read styles
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    for (int idx = 0; idx < 2; idx++) begin
      gn[idx] = 0;
      push(idx, 10, (idx == 1) ? 8'h40 : 8'h30);
      for (int c = 0; c < 80 && gn[idx] < 10; c++) begin
        tready[idx] = pat[c % 7];
        half();
        fin();
      end
      tready[idx] = 1'b1;
      chk($sformatf("bp%0d_beats", idx), 32'(gn[idx]), 32'd10);
      for (int k = 0; k < 10; k++)
        chk($sformatf("bp%0d_data%0d", idx, k), 32'(gd[idx][k]),
            32'(((idx == 1) ? 8'h40 : 8'h30) + 8'(k)));
    end

    // FIFO runs dry mid-packet, refilled five cycles later
    rst[1]      = 1'b1;
    pkt_last[1] = 8'd3;
    cyc(1);
    rst[1] = 1'b0;
    gn[1]  = 0;
    push(1, 2, 8'hC0);
    cyc(3);
    half();
    chk("gap_valid", 32'(tvalid[1]), 32'd0);
    chk("gap_busy", 32'(busy[1]), 32'd0);
    fin();
    cyc(4);
    push(1, 2, 8'hC2);
    cyc(5);
    chk("gap_beats", 32'(gn[1]), 32'd4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("gap_data%0d", k), 32'(gd[1][k]), 32'(8'hC0 + 8'(k)));
      chk($sformatf("gap_last%0d", k), 32'(gl[1][k]), (k == 3) ? 32'd1 : 32'd0);
    end
    chk("gap_cnt", 32'(pcnt[1]), 32'd1);

    // Reset while stalled with skid full
    pkt_last[1] = 8'd1;
    tready[1]   = 1'b0;
    gn[1]       = 0;
    push(1, 4, 8'hD0);
    cyc(3);
    half();
    chk("pre_rst_entries", 32'(dut1.entries), 32'd2);
    chk("pre_rst_data", 32'(tdata[1]), 32'(8'hD0));
    fin();
    rst[1] = 1'b1;
    cyc(1);
    rst[1] = 1'b0;
    half();
    chk("post_rst_valid", 32'(tvalid[1]), 32'd0);
    chk("post_rst_busy", 32'(busy[1]), 32'd0);
    chk("post_rst_cnt", 32'(pcnt[1]), 32'd0);
    fin();
    tready[1] = 1'b1;
    cyc(6);
    chk("post_rst_beats", 32'(gn[1]), 32'd2);
    chk("post_rst_data0", 32'(gd[1][0]), 32'(8'hD2));
    chk("post_rst_last0", 32'(gl[1][0]), 32'd0);
    chk("post_rst_data1", 32'(gd[1][1]), 32'(8'hD3));
    chk("post_rst_last1", 32'(gl[1][1]), 32'd1);
    chk("post_rst_pkts", 32'(pcnt[1]), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule

// File: doc/sfifo_axis_reader.md
Name: sfifo_axis_reader

Overview:
- Read-side consumer for the team's synchronous FIFOs: pops words from a FIFO read port (i_rd/o_data/o_empty style) and presents them as an AXI-stream master with full valid/ready backpressure.
- Supports first-word-fall-through FIFOs and FIFOs with one-cycle registered read latency.
- Sustains one beat per cycle through an internal 2-entry output buffer.
- Frames the stream into packets of runtime-programmable length by generating TLAST.

Parameters:
- BW, 8: data width in bits.
- LGPKT, 8: width of the packet-length input and the beat counter.
- OPT_FWFT, 1: 1 = FIFO data is valid on i_data whenever !i_empty (zero latency). 0 = i_data is valid exactly one cycle after an o_rd pulse.

Ports:
- i_clk  input  1  clock
- i_reset  input  1  synchronous reset, active-high
- o_rd  output  1  FIFO pop request
- i_data  input  BW  FIFO read data
- i_empty  input  1  FIFO empty flag
- i_pkt_last  input  LGPKT  packet length minus one, in beats
- M_AXIS_TVALID  output  1  stream valid
- M_AXIS_TREADY  input  1  stream ready
- M_AXIS_TDATA  output  BW  stream data
- M_AXIS_TLAST  output  1  last beat of packet
- o_pkt_count  output  16  count of completed packets, wraps at 2^16
- o_busy  output  1  buffered or in-flight data present

Behaviour:
- Interface: one clock, i_clk; reset is synchronous and active-high, i_reset. All state is reset to zero except where noted.
- Reset values:
  - o_rd=0 combinationally while i_reset=1.
  - M_AXIS_TVALID=0, M_AXIS_TLAST=0, o_pkt_count=0, o_busy=0.
  - Buffer entries=0, inflight=0, beat_cnt=0.
  - len_q <= i_pkt_last, captured in the reset cycle.
- Internal state:
  - 2-entry FIFO-ordered buffer: head register drives TDATA, plus a skid register.
  - entries, 0..2.
  - inflight, 0..1; always 0 when OPT_FWFT=1.
- Handshake: pop = M_AXIS_TVALID && M_AXIS_TREADY.
  - M_AXIS_TVALID = (entries != 0).
  - TDATA and TLAST hold stable while TVALID && !TREADY.
- Read issue rule: o_rd = !i_reset && !i_empty && (entries + inflight - pop < 2). o_rd is never asserted when i_empty=1.
- Capture, OPT_FWFT=1: i_data is captured in the same cycle o_rd=1.
- Capture, OPT_FWFT=0:
  - o_rd sets inflight on the next edge.
  - i_data is captured in the cycle inflight=1.
  - inflight clears unless a new o_rd occurs in that cycle.
- Write placement: a capture goes to the head if the head is empty or being popped this cycle; otherwise it goes to skid. On pop with skid full, skid moves to head.
- Simultaneous capture and pop leaves entries unchanged.
- Overflow of the 2-entry buffer is impossible by the issue rule. The bench asserts entries+inflight <= 2 every cycle.
- Throughput: with the FIFO non-empty and TREADY=1, one beat per cycle in steady state. Latency from the first non-empty cycle to TVALID:
  - OPT_FWFT=1: 1 cycle.
  - OPT_FWFT=0: 2 cycles.
- Framing:
  - M_AXIS_TLAST = (beat_cnt == len_q), derived from registered state.
  - On pop with !TLAST: beat_cnt <= beat_cnt + 1.
  - On pop with TLAST: beat_cnt <= 0, len_q <= i_pkt_last, o_pkt_count <= o_pkt_count + 1 (modulo 2^16).
  - i_pkt_last=0 gives single-beat packets.
  - len_q changes only at packet boundaries; changes to i_pkt_last mid-packet have no effect on the current packet.
- Status: o_busy = (entries != 0) || (inflight != 0).
- Reset mid-operation:
  - Buffered data is discarded.
  - In OPT_FWFT=0, data returning in the cycle after reset for a pre-reset o_rd is ignored; that word is lost, which is the documented behaviour.
  - The framing counter restarts at beat 0.

Test Plan:
1. OPT_FWFT=1, FIFO preloaded 0x11..0x18, TREADY=1, i_pkt_last=3 -> TDATA 0x11..0x18 on 8 consecutive cycles; TLAST on 0x14 and 0x18; o_pkt_count=2.
2. OPT_FWFT=0 model FIFO, 6 words 0xA0..0xA5, TREADY=1 -> first TVALID 2 cycles after the first o_rd-eligible cycle; then one beat per cycle in order; o_rd never seen with i_empty=1.
3. Backpressure: TREADY pattern 1,0,0,1,0,1,1,... over 10 words -> no loss or duplication; TDATA/TLAST stable during stalls; entries+inflight never exceeds 2.
4. i_pkt_last changed 3->1 at beat 2 of a packet -> current packet still ends at beat 3; following packets are 2 beats each.
5. FIFO runs empty mid-stream, refilled 5 cycles later -> TVALID drops after the last buffered word; resumes in order; beat_cnt continuity is preserved across the gap.
6. i_reset asserted for 1 cycle with skid full and TREADY=0 -> next cycle TVALID=0, o_busy=0, o_pkt_count=0; the next beat starts a new packet at beat_cnt=0.
